// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis LED court controller.
package tennis_pkg;

    typedef enum logic [2:0] {
        StServe,
        StToRight,
        StToLeft,
        StPoint,
        StMatchEnd
    } state_e;

    localparam logic [2:0] PT_0   = 3'd0;
    localparam logic [2:0] PT_15  = 3'd1;
    localparam logic [2:0] PT_30  = 3'd2;
    localparam logic [2:0] PT_40  = 3'd3;
    localparam logic [2:0] PT_ADV = 3'd4;

    localparam logic [3:0] POS_LEFT  = 4'd15;
    localparam logic [3:0] POS_RIGHT = 4'd0;

    function automatic logic [15:0] pos_to_light(input logic [3:0] pos);
        return 16'h0001 << pos;
    endfunction

endpackage

// File: rtl/tennis_score.sv
// Tennis point/deuce/game bookkeeping; game_won and match_won pulse in the award cycle.
module tennis_score
    import tennis_pkg::*;
#(
    parameter int unsigned GAMES_TO_WIN = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       award_valid,
    input  logic       award_winner,
    output logic [2:0] pts_left,
    output logic [2:0] pts_right,
    output logic [2:0] games_left,
    output logic [2:0] games_right,
    output logic       game_won,
    output logic       match_won
);

    localparam logic [2:0] GAMES_MAX = 3'(GAMES_TO_WIN);

    logic [2:0] pts_left_q, pts_left_d, pts_right_q, pts_right_d;
    logic [2:0] games_left_q, games_left_d, games_right_q, games_right_d;
    logic [2:0] w_pts, o_pts, w_games, w_pts_new, o_pts_new, w_games_new;

    always_comb begin
        pts_left_d    = pts_left_q;
        pts_right_d   = pts_right_q;
        games_left_d  = games_left_q;
        games_right_d = games_right_q;
        game_won      = 1'b0;
        match_won     = 1'b0;
        // Work in winner/opponent terms, then map back to left/right.
        w_pts       = award_winner ? pts_right_q : pts_left_q;
        o_pts       = award_winner ? pts_left_q : pts_right_q;
        w_games     = award_winner ? games_right_q : games_left_q;
        w_pts_new   = w_pts;
        o_pts_new   = o_pts;
        w_games_new = w_games;
        if (award_valid) begin
            if (w_pts < PT_40) begin
                w_pts_new = w_pts + 3'd1;
            end else if (w_pts == PT_40 && o_pts == PT_40) begin
                w_pts_new = PT_ADV;
            end else if (w_pts == PT_40 && o_pts == PT_ADV) begin
                o_pts_new = PT_40;
            end else begin
                game_won = 1'b1;
            end
            if (game_won) begin
                w_pts_new = PT_0;
                o_pts_new = PT_0;
                if (w_games < GAMES_MAX) begin
                    w_games_new = w_games + 3'd1;
                end
                match_won = (w_games_new == GAMES_MAX);
            end
            if (award_winner) begin
                pts_right_d   = w_pts_new;
                pts_left_d    = o_pts_new;
                games_right_d = w_games_new;
            end else begin
                pts_left_d    = w_pts_new;
                pts_right_d   = o_pts_new;
                games_left_d  = w_games_new;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pts_left_q    <= PT_0;
            pts_right_q   <= PT_0;
            games_left_q  <= 3'd0;
            games_right_q <= 3'd0;
        end else begin
            pts_left_q    <= pts_left_d;
            pts_right_q   <= pts_right_d;
            games_left_q  <= games_left_d;
            games_right_q <= games_right_d;
        end
    end

    assign pts_left    = pts_left_q;
    assign pts_right   = pts_right_q;
    assign games_left  = games_left_q;
    assign games_right = games_right_q;

endmodule

// File: rtl/tennis_match_ctrl.sv
// Tennis court sequencer: step prescaler, button synchronizers, ball FSM and score keeping.
module tennis_match_ctrl
    import tennis_pkg::*;
#(
    parameter int unsigned STEP_DIV     = 25000000,
    parameter int unsigned GAMES_TO_WIN = 6,
    parameter int unsigned POINT_STEPS  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rightplayer,
    input  logic        leftplayer,
    output logic [15:0] light,
    output logic [2:0]  pts_left,
    output logic [2:0]  pts_right,
    output logic [2:0]  games_left,
    output logic [2:0]  games_right,
    output logic        server,
    output logic        match_over
);

    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned PW = (POINT_STEPS > 1) ? $clog2(POINT_STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PT_LAST  = PW'(POINT_STEPS - 1);
    localparam logic [2:0] GAMES_MAX   = 3'(GAMES_TO_WIN);

    state_e        state_q, state_d, rally_state;
    logic [3:0]    pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pt_cnt_q, pt_cnt_d;
    logic          server_q, server_d;
    logic [3:0]    right_sync_q, left_sync_q;
    logic          right_edge, left_edge, tick, state_change;
    logic          award_valid, award_winner, game_won, match_won;

    // Bits [1:0] synchronize, [3:2] detect the rising edge.
    assign right_edge = right_sync_q[2] & ~right_sync_q[3];
    assign left_edge  = left_sync_q[2] & ~left_sync_q[3];
    assign tick       = (cnt_q == CNT_LAST);

    always_comb begin
        rally_state  = state_q;
        pos_d        = pos_q;
        award_valid  = 1'b0;
        award_winner = 1'b0;
        unique case (state_q)
            StServe: begin
                if (!server_q && left_edge) begin
                    rally_state = StToRight;
                end else if (server_q && right_edge) begin
                    rally_state = StToLeft;
                end
            end
            StToRight: begin
                if (right_edge) begin
                    if (pos_q == POS_RIGHT) begin
                        rally_state = StToLeft;
                    end else begin
                        award_valid = 1'b1;
                    end
                end else if (tick) begin
                    if (pos_q == POS_RIGHT) begin
                        award_valid = 1'b1;
                    end else begin
                        pos_d = pos_q - 4'd1;
                    end
                end
            end
            StToLeft: begin
                award_winner = 1'b1;
                if (left_edge) begin
                    if (pos_q == POS_LEFT) begin
                        rally_state = StToRight;
                    end else begin
                        award_valid = 1'b1;
                    end
                end else if (tick) begin
                    if (pos_q == POS_LEFT) begin
                        award_valid = 1'b1;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            StPoint: begin
                if (tick && pt_cnt_q == PT_LAST) begin
                    rally_state = StServe;
                    pos_d       = server_q ? POS_RIGHT : POS_LEFT;
                end
            end
            StMatchEnd: begin
            end
            default: rally_state = StServe;
        endcase
    end

    assign state_d  = award_valid ? (match_won ? StMatchEnd : StPoint) : rally_state;
    assign server_d = server_q ^ game_won;

    always_comb begin
        state_change = (state_d != state_q);
        cnt_d        = (state_change || tick) ? '0 : cnt_q + 1'b1;
        pt_cnt_d     = pt_cnt_q;
        if (state_change) begin
            pt_cnt_d = '0;
        end else if (state_q == StPoint && tick) begin
            pt_cnt_d = pt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StServe;
            pos_q        <= POS_LEFT;
            cnt_q        <= '0;
            pt_cnt_q     <= '0;
            server_q     <= 1'b0;
            right_sync_q <= '1;
            left_sync_q  <= '1;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            cnt_q        <= cnt_d;
            pt_cnt_q     <= pt_cnt_d;
            server_q     <= server_d;
            right_sync_q <= {right_sync_q[2:0], rightplayer};
            left_sync_q  <= {left_sync_q[2:0], leftplayer};
        end
    end

    tennis_score #(
        .GAMES_TO_WIN(GAMES_TO_WIN)
    ) u_score (
        .clock       (clock),
        .reset       (reset),
        .award_valid (award_valid),
        .award_winner(award_winner),
        .pts_left    (pts_left),
        .pts_right   (pts_right),
        .games_left  (games_left),
        .games_right (games_right),
        .game_won    (game_won),
        .match_won   (match_won)
    );

    always_comb begin
        light = 16'h0000;
        unique case (state_q)
            StServe, StToRight, StToLeft: light = pos_to_light(pos_q);
            StMatchEnd: light = (games_left == GAMES_MAX) ? 16'hFF00 : 16'h00FF;
            default:    light = 16'h0000;
        endcase
    end

    assign server     = server_q;
    assign match_over = (state_q == StMatchEnd);

endmodule

// File: tb/tb_tennis_match_ctrl.sv
// Scoreboard bench: stimulus queues every expected output change with its edge number,
// a monitor pops and compares on each observed change of the output vector.
module tb_tennis_match_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rightplayer = 1'b0;
    logic        leftplayer = 1'b0;
    logic [15:0] light;
    logic [2:0]  pts_left, pts_right, games_left, games_right;
    logic        server, match_over;

    tennis_match_ctrl #(
        .STEP_DIV    (4),
        .GAMES_TO_WIN(2),
        .POINT_STEPS (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rightplayer(rightplayer),
        .leftplayer (leftplayer),
        .light      (light),
        .pts_left   (pts_left),
        .pts_right  (pts_right),
        .games_left (games_left),
        .games_right(games_right),
        .server     (server),
        .match_over (match_over)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] light;
        logic [2:0]  pl, pr, gl, gr;
        logic        srv, mo;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 0;
    logic [2:0] cur_pl = 0, cur_pr = 0, cur_gl = 0, cur_gr = 0;
    logic       cur_srv = 0;

    task automatic push(input string tag, input logic [15:0] l, input logic [2:0] pl, pr, gl,
                        gr, input logic srv, mo, input int c);
        exp_t e;
        e.tag = tag; e.light = l; e.pl = pl; e.pr = pr; e.gl = gl; e.gr = gr;
        e.srv = srv; e.mo = mo; e.cyc = c;
        sb.push_back(e);
    endtask

    // Ball steps after a serve/return at edge start, one position every 4 edges.
    task automatic push_run(input int start, input bit to_left, input int n);
        logic [15:0] one;
        logic [15:0] l;
        one = 16'h0001;
        for (int k = 1; k <= n; k++) begin
            l = to_left ? (one << k) : (one << (15 - k));
            push("step", l, cur_pl, cur_pr, cur_gl, cur_gr, cur_srv, 1'b0, start + 4 * k);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Press set before edge N=cyc+1 acts on edge N+3.
    task automatic press(input bit right_btn, output int act);
        act = cyc + 4;
        if (right_btn) rightplayer = 1'b1;
        else leftplayer = 1'b1;
        @(negedge clock);
        @(negedge clock);
        if (right_btn) rightplayer = 1'b0;
        else leftplayer = 1'b0;
    endtask

    task automatic play_point(input string tag, input bit winner, input logic [2:0] epl, epr,
                              egl, egr, input logic esrv, emo);
        int a, r, p;
        bit s;
        logic [15:0] end_light;
        s = cur_srv;
        press(s, a);
        if (winner == s) begin
            press(~s, p);
        end else begin
            push_run(a, s, 15);
            wait_until(a + 58);
            press(~s, r);
            press(s, p);
        end
        end_light = emo ? (winner ? 16'h00FF : 16'hFF00) : 16'h0000;
        push(tag, end_light, epl, epr, egl, egr, esrv, emo, p);
        if (!emo) begin
            push({tag, "_serve"}, esrv ? 16'h0001 : 16'h8000, epl, epr, egl, egr, esrv, 1'b0,
                 p + 8);
        end
        cur_pl = epl; cur_pr = epr; cur_gl = egl; cur_gr = egr; cur_srv = esrv;
        wait_until(emo ? p + 2 : p + 9);
    endtask

    // Monitor: every change of the observed outputs must match the next queued expectation.
    initial begin
        exp_t e;
        logic [29:0] obs, prev_obs;
        prev_obs = 'x;
        while (!done) begin
            @(negedge clock);
            obs = {light, pts_left, pts_right, games_left, games_right, server, match_over};
            if (obs !== prev_obs) begin
                prev_obs = obs;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change @%0d: got light=%h pts=%0d/%0d games=%0d/%0d srv=%0b over=%0b, want no change",
                             cyc, light, pts_left, pts_right, games_left, games_right, server,
                             match_over);
                end else begin
                    e = sb.pop_front();
                    if (obs !== {e.light, e.pl, e.pr, e.gl, e.gr, e.srv, e.mo} || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL %s: got light=%h pts=%0d/%0d games=%0d/%0d srv=%0b over=%0b @%0d, want light=%h pts=%0d/%0d games=%0d/%0d srv=%0b over=%0b @%0d",
                                 e.tag, light, pts_left, pts_right, games_left, games_right,
                                 server, match_over, cyc, e.light, e.pl, e.pr, e.gl, e.gr,
                                 e.srv, e.mo, e.cyc);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_changes: got %0d expectations unmatched, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus, want completion");
        $fatal(1);
    end

    initial begin
        int a, r, e, x;
        // Reset held for two edges.
        push("reset", 16'h8000, 0, 0, 0, 0, 1'b0, 1'b0, 1);
        wait_until(2);
        reset = 1'b0;

        // Receiver pressing during SERVE is ignored.
        press(1'b1, x);
        wait_until(x + 6);

        // Left serves, right never returns.
        press(1'b0, a);
        push_run(a, 1'b0, 15);
        push("miss_right", 16'h0000, 1, 0, 0, 0, 1'b0, 1'b0, a + 64);
        push("serve_after_miss", 16'h8000, 1, 0, 0, 0, 1'b0, 1'b0, a + 72);
        cur_pl = 1;
        wait_until(a + 74);

        // Left serves, sender press ignored, right returns at 0001, left misses at 8000.
        press(1'b0, a);
        push_run(a, 1'b0, 15);
        wait_until(a + 20);
        press(1'b0, x);
        wait_until(a + 58);
        press(1'b1, r);
        push_run(r, 1'b1, 15);
        push("miss_left", 16'h0000, 1, 1, 0, 0, 1'b0, 1'b0, r + 64);
        push("serve_after_return", 16'h8000, 1, 1, 0, 0, 1'b0, 1'b0, r + 72);
        cur_pr = 1;
        wait_until(r + 74);

        // Early right press at 0020 acts exactly three edges after first sample.
        press(1'b0, a);
        push_run(a, 1'b0, 10);
        wait_until(a + 38);
        press(1'b1, e);
        push("early_press", 16'h0000, 2, 1, 0, 0, 1'b0, 1'b0, e);
        push("serve_after_early", 16'h8000, 2, 1, 0, 0, 1'b0, 1'b0, e + 8);
        cur_pl = 2;
        wait_until(e + 10);

        // Deuce and advantage, then first game to left.
        play_point("pt_40_15",    1'b0, 3, 1, 0, 0, 1'b0, 1'b0);
        play_point("pt_40_30",    1'b1, 3, 2, 0, 0, 1'b0, 1'b0);
        play_point("deuce",       1'b1, 3, 3, 0, 0, 1'b0, 1'b0);
        play_point("adv_left",    1'b0, 4, 3, 0, 0, 1'b0, 1'b0);
        play_point("back_deuce",  1'b1, 3, 3, 0, 0, 1'b0, 1'b0);
        play_point("adv_left2",   1'b0, 4, 3, 0, 0, 1'b0, 1'b0);
        play_point("game_left",   1'b0, 0, 0, 1, 0, 1'b1, 1'b0);

        // Right serves now; left takes the second game and the match.
        play_point("g2_15_0",     1'b0, 1, 0, 1, 0, 1'b1, 1'b0);
        play_point("g2_30_0",     1'b0, 2, 0, 1, 0, 1'b1, 1'b0);
        play_point("g2_40_0",     1'b0, 3, 0, 1, 0, 1'b1, 1'b0);
        play_point("match_left",  1'b0, 0, 0, 2, 0, 1'b0, 1'b1);

        // Match end ignores both buttons.
        press(1'b0, x);
        press(1'b1, x);
        wait_until(x + 8);

        // Reset with left held through it must not produce a serve.
        leftplayer = 1'b1;
        reset = 1'b1;
        push("reset_after_match", 16'h8000, 0, 0, 0, 0, 1'b0, 1'b0, cyc + 1);
        cur_pl = 0; cur_pr = 0; cur_gl = 0; cur_gr = 0; cur_srv = 1'b0;
        x = cyc;
        wait_until(x + 2);
        reset = 1'b0;
        wait_until(x + 8);
        leftplayer = 1'b0;
        wait_until(x + 16);

        // Reset mid-rally returns to serve with no point awarded.
        press(1'b0, a);
        push_run(a, 1'b0, 3);
        wait_until(a + 13);
        reset = 1'b1;
        push("reset_mid_rally", 16'h8000, 0, 0, 0, 0, 1'b0, 1'b0, a + 14);
        wait_until(a + 15);
        reset = 1'b0;
        wait_until(a + 30);
        done = 1;
    end

endmodule

// File: doc/tennis_match_ctrl.md
Name: tennis_match_ctrl

Overview:
- Game/score sequencer for the tennis LED court.
- Owns the ball: position and direction on light[15:0], serve hand-off, and hit/miss/early-press judgement from the rightplayer/leftplayer buttons.
- Keeps tennis scoring: points, deuce/advantage, games, match end.
- Drives light directly; point/game/server outputs feed the existing 7-segment display driver (AN_Out/C_Out), which is out of scope.

Parameters:
- STEP_DIV, 25000000: clock cycles per ball step (tick).
- GAMES_TO_WIN, 6: games needed to win the match (range 1..7).
- POINT_STEPS, 2: ticks of blank court after a point.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rightplayer  in  1  right button, asynchronous level
- leftplayer  in  1  left button, asynchronous level
- light  out  16  court LEDs; bit15 = left end, bit0 = right end
- pts_left  out  3  left point code: 0/1/2/3 = 0/15/30/40, 4 = ADV
- pts_right  out  3  right point code, same encoding
- games_left  out  3  left games won
- games_right  out  3  right games won
- server  out  1  0 = left serves, 1 = right serves
- match_over  out  1  high once the match is decided

Behaviour:
- Reset (clock edge with reset=1): state SERVE, server=0, pos=15, light=16'h8000, all points/games 0, match_over=0, tick counter 0. Synchronizer flops load 1, so a button held through reset produces no edge.
- Inputs: 2-flop synchronizer, then edge = s2 & ~s3. A press first sampled high on edge N acts on edge N+3.
- Tick: counter counts 0..STEP_DIV-1 and pulses for one cycle at STEP_DIV-1. Counter clears on every state change.
- States: SERVE, TO_RIGHT (pos decreasing), TO_LEFT (pos increasing), POINT, MATCH_END.
- In play, light = 1<<pos. In POINT, light = 0.
- SERVE:
  - pos is 15 if server=0, otherwise 0.
  - Only the server's edge is honoured: go to TO_RIGHT (left serves) or TO_LEFT (right serves).
  - The first tick moves the ball one position.
- TO_RIGHT; the receiver is right, the mirror rules apply for TO_LEFT:
  - Right edge with pos==0: go to TO_LEFT, pos stays 0, and the next tick moves it to 1.
  - Right edge with pos!=0 (early press): point to left.
  - Tick with pos==0 and no edge: point to left (miss).
  - Tick otherwise: pos-1.
  - Left (sender) edges are ignored.
  - An edge and a tick in the same cycle: the edge is judged first.
- Point award, registered on entry to POINT. For winner w and loser o:
  - w<3: w+1.
  - w==3 and o<3: game to w.
  - w==3 and o==3: w=4 (ADV).
  - w==3 and o==4: o=3 (back to deuce).
  - w==4: game to w.
- Game: both points reset to 0, games_w+1, server toggles. If games_w==GAMES_TO_WIN, go to MATCH_END instead of POINT.
- POINT: hold for POINT_STEPS ticks, then SERVE.
- MATCH_END:
  - light = 16'hFF00 if left won, 16'h00FF if right won.
  - match_over=1; all inputs ignored.
  - Exit only by reset.
- Reset asserted mid-rally or mid-POINT: full reset values on that edge, with no award.
- Game counters never exceed GAMES_TO_WIN.

Decomposition:
- tennis_pkg: state enum; point codes PT_0, PT_15, PT_30, PT_40, PT_ADV; POS_LEFT=15, POS_RIGHT=0.
- Sub-module tennis_score: point/deuce/game logic.
  - Inputs: clock, reset, award_valid, award_winner.
  - Outputs: points, games, game_won pulse, match_won pulse.
- Prescaler, synchronizers and ball FSM stay in tennis_match_ctrl.

Test Plan: run with STEP_DIV=4, GAMES_TO_WIN=2, POINT_STEPS=2.
- Reset: hold reset for 2 edges -> light=8000, all points/games 0, server=0, match_over=0. Right press while in SERVE -> no change.
- Serve, no return: left press -> light 4000, 2000, ... 0001, one step per 4 cycles. Next tick -> light=0, pts_left=1. After 8 cycles -> SERVE, light=8000.
- Return: right press while light=0001 -> next tick light=0002, then continues leftward. Left ignores it at 8000 -> pts_right=1.
- Early press: right press at light=0020 -> on edge N+3, light=0 and pts_left increments.
- Deuce/advantage:
  - Reach 3-3, left wins a point -> pts_left=4.
  - Right wins a point -> both 3.
  - Left wins twice -> games_left=1, points 0/0, server=1, SERVE light=0001.
- Match end and reset: left wins the 2nd game -> match_over=1, light=FF00, presses ignored. Reset -> reset values. Separately, reset asserted mid-rally -> light=8000 with no point awarded.
